// File: rtl/mealy_evt_pkg.sv
// Shared definitions for the mealy event counter: pattern-detector codes and
// the report buffer state encoding.
package mealy_evt_pkg;

    localparam logic [1:0] PAT_NONE = 2'b00;
    localparam logic [1:0] PAT_RISE = 2'b01;
    localparam logic [1:0] PAT_FALL = 2'b10;
    localparam logic [1:0] PAT_ILL  = 2'b11;

    typedef enum logic {
        RB_EMPTY = 1'b0,
        RB_FULL  = 1'b1
    } rb_state_e;

endpackage

// File: rtl/mealy_evt_rpt_buf.sv
// One-entry report register with valid/ready handshake; remembers windows that
// were discarded while full and flags them on the next report that gets through.
module mealy_evt_rpt_buf
    import mealy_evt_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             win_end,
    input  logic [CNT_W-1:0] win_fall,
    input  logic [CNT_W-1:0] win_rise,
    input  logic             rep_ready,
    output logic             rep_valid,
    output logic [CNT_W-1:0] rep_fall,
    output logic [CNT_W-1:0] rep_rise,
    output logic             rep_drop
);

    rb_state_e        state_q, state_d;
    logic [CNT_W-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic             drop_q, drop_d;
    logic             drop_pend_q, drop_pend_d;

    always_comb begin
        state_d     = state_q;
        fall_d      = fall_q;
        rise_d      = rise_q;
        drop_d      = drop_q;
        drop_pend_d = drop_pend_q;
        unique case (state_q)
            RB_EMPTY: begin
                if (win_end) begin
                    state_d     = RB_FULL;
                    fall_d      = win_fall;
                    rise_d      = win_rise;
                    drop_d      = drop_pend_q;
                    drop_pend_d = 1'b0;
                end
            end
            RB_FULL: begin
                if (rep_ready) begin
                    // The held report leaves on this edge, so a coincident window
                    // end takes the slot instead of being dropped.
                    if (win_end) begin
                        fall_d      = win_fall;
                        rise_d      = win_rise;
                        drop_d      = drop_pend_q;
                        drop_pend_d = 1'b0;
                    end else begin
                        state_d = RB_EMPTY;
                    end
                end else if (win_end) begin
                    drop_pend_d = 1'b1;
                end
            end
            default: state_d = RB_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RB_EMPTY;
            fall_q      <= '0;
            rise_q      <= '0;
            drop_q      <= 1'b0;
            drop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fall_q      <= fall_d;
            rise_q      <= rise_d;
            drop_q      <= drop_d;
            drop_pend_q <= drop_pend_d;
        end
    end

    assign rep_valid = (state_q == RB_FULL);
    assign rep_fall  = fall_q;
    assign rep_rise  = rise_q;
    assign rep_drop  = drop_q;

endmodule

// File: rtl/mealy_event_counter.sv
// Counts rise/fall event codes over windows of WINDOW valid samples and reports
// each window through a one-deep buffer. MEALY_EVT_ERR_EN adds the sticky err flag.
module mealy_event_counter
    import mealy_evt_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [1:0]       pat,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic [CNT_W-1:0] rep_fall,
    output logic [CNT_W-1:0] rep_rise,
    output logic             rep_drop
`ifdef MEALY_EVT_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);

    if (WINDOW < 2 || (64'd1 << CNT_W) <= 64'(WINDOW)) begin : g_bad_param
        $error("mealy_event_counter: need WINDOW >= 2 and 2**CNT_W > WINDOW");
    end

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_rise_q, cnt_rise_d;
    logic [CNT_W-1:0] cnt_fall_q, cnt_fall_d;
    logic [CNT_W-1:0] sum_rise, sum_fall;
    logic             is_rise, is_fall, win_end;

    always_comb begin
        is_rise  = in_valid && (pat == PAT_RISE);
        is_fall  = in_valid && (pat == PAT_FALL);
        // Window totals include the current sample so the last one is reported.
        sum_rise = cnt_rise_q + CNT_W'(is_rise);
        sum_fall = cnt_fall_q + CNT_W'(is_fall);
        win_end  = in_valid && (idx_q == IDX_LAST);

        idx_d      = idx_q;
        cnt_rise_d = cnt_rise_q;
        cnt_fall_d = cnt_fall_q;
        if (win_end) begin
            idx_d      = '0;
            cnt_rise_d = '0;
            cnt_fall_d = '0;
        end else if (in_valid) begin
            idx_d      = idx_q + IDX_W'(1);
            cnt_rise_d = sum_rise;
            cnt_fall_d = sum_fall;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx_q      <= '0;
            cnt_rise_q <= '0;
            cnt_fall_q <= '0;
        end else begin
            idx_q      <= idx_d;
            cnt_rise_q <= cnt_rise_d;
            cnt_fall_q <= cnt_fall_d;
        end
    end

`ifdef MEALY_EVT_ERR_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (in_valid && (pat == PAT_ILL)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    mealy_evt_rpt_buf #(
        .CNT_W(CNT_W)
    ) u_rpt_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .win_end  (win_end),
        .win_fall (sum_fall),
        .win_rise (sum_rise),
        .rep_ready(rep_ready),
        .rep_valid(rep_valid),
        .rep_fall (rep_fall),
        .rep_rise (rep_rise),
        .rep_drop (rep_drop)
    );

endmodule

// File: tb/tb_mealy_event_counter.sv
// Directed bench for mealy_event_counter (WINDOW=16, CNT_W=5); err checks are
// active when MEALY_EVT_ERR_EN is defined.
module tb_mealy_event_counter;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] F = 2'b10;
    localparam logic [1:0] I = 2'b11;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] pat = 2'b00;
    logic       rep_ready = 1'b0;
    logic       rep_valid;
    logic [4:0] rep_fall;
    logic [4:0] rep_rise;
    logic       rep_drop;
`ifdef MEALY_EVT_ERR_EN
    logic       err;
`endif

    // {rep_valid, rep_fall, rep_rise, rep_drop}
    logic [11:0] obs;
    assign obs = {rep_valid, rep_fall, rep_rise, rep_drop};

    int n_tests = 0;
    int n_fail  = 0;

    mealy_event_counter #(
        .WINDOW(16),
        .CNT_W (5)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .pat      (pat),
        .rep_valid(rep_valid),
        .rep_ready(rep_ready),
        .rep_fall (rep_fall),
        .rep_rise (rep_rise),
        .rep_drop (rep_drop)
`ifdef MEALY_EVT_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Feeds samples first..last of a packed 16-sample window (sample i at w[2i+:2]).
    task automatic feed(input logic [31:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            in_valid = 1'b1;
            pat      = w[2*i+:2];
            tick();
        end
        in_valid = 1'b0;
        pat      = N;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        pat       = R;
        rep_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 12'h000);
        end
`ifdef MEALY_EVT_ERR_EN
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
        reset_n  = 1'b1;
        in_valid = 1'b0;
        pat      = N;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] w;
        w = '0;
        w[2*1+:2]  = R;
        w[2*4+:2]  = R;
        w[2*7+:2]  = R;
        w[2*2+:2]  = F;
        w[2*10+:2] = F;
        rep_ready = 1'b1;
        feed(w, 0, 14);
        n_tests++;
        if (rep_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: rep_valid got %b want 0", rep_valid);
        end
        feed(w, 15, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd2, 5'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_report: got %h want %h", obs, {1'b1, 5'd2, 5'd3, 1'b0});
        end
        tick();
        n_tests++;
        if (rep_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: rep_valid got %b want 0", rep_valid);
        end
    endtask

    task automatic test_last_sample();
        logic [31:0] w;
        w = '0;
        w[2*5+:2]  = F;
        w[2*15+:2] = F;
        rep_ready = 1'b1;
        feed(w, 0, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd2, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL last_sample: got %h want %h", obs, {1'b1, 5'd2, 5'd0, 1'b0});
        end
        w = '0;
        w[2*0+:2] = R;
        feed(w, 0, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd0, 5'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL next_window_clear: got %h want %h", obs, {1'b1, 5'd0, 5'd1, 1'b0});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        w = 32'h5555_5555;
        rep_ready = 1'b0;
        feed(w, 0, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd0, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_first: got %h want %h", obs, {1'b1, 5'd0, 5'd16, 1'b0});
        end
        for (int k = 0; k < 32; k++) begin
            in_valid = 1'b1;
            pat      = R;
            tick();
            n_tests++;
            if (obs !== {1'b1, 5'd0, 5'd16, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h want %h", k, obs,
                         {1'b1, 5'd0, 5'd16, 1'b0});
            end
        end
        in_valid  = 1'b0;
        pat       = N;
        rep_ready = 1'b1;
        tick();
        n_tests++;
        if (rep_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: rep_valid got %b want 0", rep_valid);
        end
        feed(w, 0, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd0, 5'd16, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_drop_flag: got %h want %h", obs, {1'b1, 5'd0, 5'd16, 1'b1});
        end
        feed(w, 0, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd0, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_drop_clear: got %h want %h", obs, {1'b1, 5'd0, 5'd16, 1'b0});
        end
        tick();
    endtask

    task automatic test_sparse();
        logic [31:0] w;
        logic        early;
        w = '0;
        for (int i = 0; i < 5; i++) w[2*i+:2] = R;
        w[2*5+:2] = F;
        w[2*6+:2] = F;
        early     = 1'b0;
        rep_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            pat      = w[2*i+:2];
            tick();
            if (i < 15) begin
                if (rep_valid) early = 1'b1;
                in_valid = 1'b0;
                pat      = (i % 2 == 0) ? I : R;
                tick();
                if (rep_valid) early = 1'b1;
            end
        end
        in_valid = 1'b0;
        pat      = N;
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse_early: premature rep_valid seen %b want 0", early);
        end
        n_tests++;
        if (obs !== {1'b1, 5'd2, 5'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL sparse_report: got %h want %h", obs, {1'b1, 5'd2, 5'd5, 1'b0});
        end
`ifdef MEALY_EVT_ERR_EN
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse_err_idle: got %b want 0", err);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        w = 32'h5555_5555;
        rep_ready = 1'b0;
        feed(w, 0, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd0, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_pending: got %h want %h", obs, {1'b1, 5'd0, 5'd16, 1'b0});
        end
        feed(w, 0, 8);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        pat      = R;
        tick();
        n_tests++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h want %h", obs, 12'h000);
        end
        reset_n   = 1'b1;
        rep_ready = 1'b1;
        feed(w, 0, 14);
        n_tests++;
        if (rep_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_early: rep_valid got %b want 0", rep_valid);
        end
        feed(w, 15, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd0, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got %h want %h", obs, {1'b1, 5'd0, 5'd16, 1'b0});
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        w = '0;
        w[2*0+:2] = R;
        w[2*1+:2] = R;
        w[2*3+:2] = I;
        w[2*8+:2] = F;
        rep_ready = 1'b1;
        feed(w, 0, 3);
`ifdef MEALY_EVT_ERR_EN
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err_set: got %b want 1", err);
        end
`endif
        feed(w, 4, 15);
        n_tests++;
        if (obs !== {1'b1, 5'd1, 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_counts: got %h want %h", obs, {1'b1, 5'd1, 5'd2, 1'b0});
        end
`ifdef MEALY_EVT_ERR_EN
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err_sticky: got %b want 1", err);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err_reset: got %b want 0", err);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_sample();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mealy_event_counter.md
# mealy_event_counter

Downstream consumer of the 2-bit pattern-detector output stream (bit 1 = "110" falling-run event, bit 0 = "001" rising-run event). It counts both event types over fixed windows of WINDOW valid input samples. At each window end it emits one report through a valid/ready handshake, buffered one deep, and flags reports that were lost and codes that are illegal.

## Interface
Parameters:
- WINDOW, 16: valid samples per window; ≥ 2.
- CNT_W, 5: counter and report width; must satisfy 2^CNT_W > WINDOW.

Ports:
- clock  in  1  rising-edge clock; one clock domain.
- reset_n  in  1  synchronous, active-low reset; sampled on posedge clock.
- in_valid  in  1  pat is valid this cycle.
- pat  in  2  {fall, rise} event code from the pattern detector.
- rep_valid  out  1  report available.
- rep_ready  in  1  consumer accepts the report.
- rep_fall  out  CNT_W  count of code 2'b10 in the reported window.
- rep_rise  out  CNT_W  count of code 2'b01 in the reported window.
- rep_drop  out  1  at least one earlier window report was discarded before this one.
- err  out  1  sticky flag: illegal code 2'b11 seen. Present only with MEALY_EVT_ERR_EN.

## Operation
- Sample counter idx runs 0..WINDOW-1. It advances only on in_valid and wraps to 0 after WINDOW-1.
- Per valid sample:
  - 2'b01 increments cnt_rise.
  - 2'b10 increments cnt_fall.
  - 2'b00 and 2'b11 change neither counter.
- Window end is a valid sample with idx == WINDOW-1. On that edge:
  - The final counts, including this sample's contribution, go to the report path.
  - cnt_rise, cnt_fall and idx clear to 0.
- Counting never stalls. Input is accepted every cycle, regardless of report state.
- Report buffer has two states, EMPTY and FULL:
  - EMPTY → FULL on window end. rep_* are loaded; rep_drop = drop_pend; drop_pend clears.
  - FULL with rep_ready and no window end → EMPTY.
  - FULL with rep_ready and window end in the same cycle → stays FULL with the new report loaded. No drop.
  - FULL with no rep_ready and window end → stays FULL. The existing report is held unchanged; the new report is discarded and drop_pend is set.
- rep_fall, rep_rise and rep_drop stay stable while rep_valid=1 and rep_ready=0.
- Counter arithmetic is unsigned CNT_W bits. Overflow is impossible given the parameter rule.
- Illegal parameters are rejected by a simulation-time check ($error at elaboration).

## Timing
- Reset values: rep_valid=0, rep_fall=0, rep_rise=0, rep_drop=0, err=0. Internally idx=0, counters=0, drop_pend=0, buffer EMPTY.
- Reset asserted mid-window or with a report pending discards all of that state. The first post-reset window starts at the first in_valid sample.
- Latency: rep_valid rises on the clock edge that samples the window-end input, visible the cycle after the sample is presented.
- A handshake completes on any posedge where rep_valid && rep_ready. rep_ready may be held high continuously.
- No combinational path from pat or in_valid to any output. All outputs are registered.

## Configuration
- MEALY_EVT_ERR_EN defined:
  - err port exists.
  - err is set on the posedge that samples in_valid && pat==2'b11, and clears only on reset.
- MEALY_EVT_ERR_EN undefined:
  - err port and its logic are removed.
  - 2'b11 is silently ignored and counts as a sample toward WINDOW.

## Structure
- Shared package mealy_evt_pkg holds:
  - Code constants PAT_NONE=2'b00, PAT_RISE=2'b01, PAT_FALL=2'b10, PAT_ILL=2'b11.
  - Buffer state enum {RB_EMPTY, RB_FULL}.
- Sub-module mealy_evt_rpt_buf implements the one-entry report register, handshake and drop_pend logic.
- The top level holds idx, the two counters and err.

## Test plan
Defaults WINDOW=16, CNT_W=5 unless stated.
- Reset, then 16 valid samples of which 3 are 2'b01 and 2 are 2'b10, rep_ready=1 → one report: rep_rise=3, rep_fall=2, rep_drop=0. rep_valid is high for exactly one cycle.
- Window whose last sample is 2'b10, preceded by one earlier 2'b10 → rep_fall=2, confirming the last sample is counted. The next window starts from 0.
- rep_ready=0 across three consecutive window ends (all samples 2'b01) → first report held: rep_rise=16, stable throughout. Then raise rep_ready, finish a fourth window → rep_rise=16 with rep_drop=1. A fifth window gives rep_drop=0.
- in_valid toggled every other cycle → a report appears only after 16 valid samples, i.e. about 32 cycles. Counts are unaffected by the idle cycles.
- Drive reset_n=0 for one cycle at sample 9, with a report pending → all outputs 0 on the next cycle. The next report needs 16 fresh samples.
- With MEALY_EVT_ERR_EN, one valid 2'b11 → err=1 on the next cycle and it stays 1; rep_rise and rep_fall are unchanged by that sample. Without the macro, the same stimulus yields identical reports.
